vpu_src_operand_ctrl: RTL
=========================

# vpu_src_operand_ctrl

Sequencer for the per-port source operand queues of the VPU. On an instruction start it issues SRAM row reads for each active source port under a credit scheme that can never overflow a queue. It turns each read into a queue write one cycle later. It then pops operand beats from all active queues in lockstep toward the vector lanes, and pulses `done_o` after the last beat. It sits between the instruction decoder and the source operand queue array; SRAM read data goes straight to the queues' write-data inputs.

## Interface
- `SRAM_R_PORT_CNT`, 3, number of source ports/queues (from VPU_PKG)
- `DIM_SIZE`, 512, bits per SRAM row = queue write width
- `BEAT_W`, 128, `OPERAND_WIDTH*VLANE_CNT`, queue read width
- `QUEUE_DEPTH`, 4, rows per queue (`OPERAND_QUEUE_DEPTH`)
- `SRAM_ADDR_W`, 10, SRAM row address width
- `ROW_CNT_W`, 8, width of row count
- `clk  in  1` clock
- `rst_n  in  1` reset; one clock; reset is asynchronous and active-low
- `start_i  in  1` start instruction; sampled only in IDLE
- `src_mask_i  in  SRAM_R_PORT_CNT` active source ports, latched at start
- `src_addr_i[SRAM_R_PORT_CNT]  in  SRAM_ADDR_W` base row address per port, latched at start
- `row_cnt_i  in  ROW_CNT_W` rows per operand, latched at start
- `busy_o  out  1` high in RUN and DONE
- `done_o  out  1` one-cycle pulse in DONE
- `sram_rden_o[SRAM_R_PORT_CNT]  out  1` SRAM read request
- `sram_raddr_o[SRAM_R_PORT_CNT]  out  SRAM_ADDR_W` SRAM read address
- `q_wren_o[SRAM_R_PORT_CNT]  out  1` queue write enable
- `q_rden_o[SRAM_R_PORT_CNT]  out  1` queue read enable
- `q_rdempty_i[SRAM_R_PORT_CNT]  in  1` queue read-side empty
- `issue_ready_i  in  1` lanes accept a beat this cycle
- `operand_valid_o  out  1` beat popped this cycle
- `perf_stall_cnt_o  out  32` starvation counter (see Configuration)

## Operation
- `BEATS = DIM_SIZE/BEAT_W`. This is a compile-time integer; a non-integer ratio is an elaboration error.
- FSM states:
  - IDLE → RUN on `start_i`. If the latched row count is 0 or the mask is 0, IDLE → DONE instead.
  - RUN → DONE when the last beat pops.
  - DONE → IDLE unconditionally.
- RUN, per active port p:
  - Row counter `rows_left`, address register `addr`, credit counter `cred` (0..QUEUE_DEPTH, init QUEUE_DEPTH).
  - `sram_rden_o[p] = RUN & active & rows_left!=0 & cred!=0`, combinational from registered state.
  - On issue: `addr+1`, wrapping modulo 2^SRAM_ADDR_W; `rows_left-1`; `cred-1`.
  - `q_wren_o[p]` is `sram_rden_o[p]` registered one cycle (SRAM read latency 1).
- Pop, all ports in lockstep:
  - `pop = RUN & issue_ready_i & AND over active p of !q_rdempty_i[p]`.
  - `q_rden_o[p] = pop & active[p]`. `operand_valid_o = pop`.
  - Beat counter counts 0..BEATS-1. On wrap, every active `cred` increments (one row freed).
  - Simultaneous issue and row-free on the same port: `cred` is unchanged.
  - Total pops = `row_cnt*BEATS`. The last pop moves to DONE.
- Inactive ports never assert any enable.
- `start_i` outside IDLE is ignored. Inputs are not re-sampled until IDLE.

## Timing
- Reset values: state IDLE, all outputs 0, counters 0, `cred`=QUEUE_DEPTH, `perf_stall_cnt_o`=0.
- `start_i` at edge T: first `sram_rden_o` in cycle T+1; first `q_wren_o` in cycle T+2. The first pop depends on the queue's empty-flag latency.
- Steady state with `issue_ready_i`=1: one pop per cycle, no bubbles if QUEUE_DEPTH ≥ 2.
- `done_o` asserts the cycle after the last pop, for exactly one cycle. `busy_o` drops the cycle after that.
- Reset mid-RUN returns to IDLE immediately. In-flight `q_wren_o` is dropped. Queues share `rst_n` and clear together.

## Configuration
- `VPU_SRC_CTRL_PERF_EN`:
  - Defined: a 32-bit saturating counter increments every RUN cycle with `issue_ready_i`=1 and `pop`=0. It clears at start; the value is held after DONE.
  - Undefined: no counter logic; `perf_stall_cnt_o` is tied to 0.

## Structure
- VPU_PKG holds `SRAM_R_PORT_CNT`, `DIM_SIZE`, `OPERAND_WIDTH`, `VLANE_CNT`, `OPERAND_QUEUE_DEPTH`, `SRAM_ADDR_W` and the FSM state enum typedef `src_ctrl_state_t`.
- Sub-module `vpu_src_port_fetch` holds one port's address, row counter, credit counter and wren delay. It is instantiated per port in a generate loop. The top holds the FSM, beat counter and pop logic.

## Test plan
- mask=3'b001, row_cnt=1, addr=0x10, ready=1, FIFO model → one read at 0x10, 4 pops, `done_o` once, `busy_o` low after.
- mask=3'b111, row_cnt=6, ready=0 for 20 cycles → exactly 4 reads per port (credits exhausted), no pops, no overflow; release ready → 24 lockstep pops, 6 reads per port total.
- addr=0x3FE, row_cnt=3 → addresses 0x3FE, 0x3FF, 0x000.
- row_cnt=0 or mask=0 → DONE the cycle after start, no reads, no pops.
- Port 1 empty-flag held high for 5 cycles mid-run → no `q_rden_o` on any port during that window; with PERF_EN, stall count = 5.
- `rst_n` low mid-RUN, then start row_cnt=2 → all outputs 0 during reset; clean 8-pop run after.

Source files
------------

// File: rtl/vpu_src_operand_ctrl_pkg.sv
// Shared VPU constants and the source-operand sequencer state type.
package vpu_src_operand_ctrl_pkg;
    localparam int SRAM_R_PORT_CNT     = 3;
    localparam int DIM_SIZE            = 512;
    localparam int OPERAND_WIDTH       = 32;
    localparam int VLANE_CNT           = 4;
    localparam int BEAT_W              = OPERAND_WIDTH * VLANE_CNT;
    localparam int OPERAND_QUEUE_DEPTH = 4;
    localparam int SRAM_ADDR_W         = 10;
    localparam int ROW_CNT_W           = 8;

    localparam int BEATS      = DIM_SIZE / BEAT_W;
    localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CRED_W     = $clog2(OPERAND_QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } src_ctrl_state_t;
endpackage

// File: rtl/vpu_src_port_fetch.sv
// One source port: row address, rows still to read, queue credits and the
// one-cycle SRAM-read to queue-write delay.
module vpu_src_port_fetch
    import vpu_src_operand_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   active,
    input  logic                   run,
    input  logic                   row_free,
    input  logic [SRAM_ADDR_W-1:0] base_addr,
    input  logic [ROW_CNT_W-1:0]   row_cnt,
    output logic                   sram_rden,
    output logic [SRAM_ADDR_W-1:0] sram_raddr,
    output logic                   q_wren
);
    logic [SRAM_ADDR_W-1:0] addr;
    logic [ROW_CNT_W-1:0]   rows_left;
    logic [CRED_W-1:0]      cred;
    logic                   freed;

    assign sram_rden  = run & active & (rows_left != '0) & (cred != '0);
    assign sram_raddr = addr;
    assign freed      = row_free & active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            rows_left <= '0;
            cred      <= CRED_W'(OPERAND_QUEUE_DEPTH);
            q_wren    <= 1'b0;
        end else begin
            q_wren <= sram_rden;
            if (load) begin
                addr      <= base_addr;
                rows_left <= row_cnt;
                cred      <= CRED_W'(OPERAND_QUEUE_DEPTH);
            end else begin
                if (sram_rden) begin
                    addr      <= addr + SRAM_ADDR_W'(1);
                    rows_left <= rows_left - ROW_CNT_W'(1);
                end
                // a read and a freed row in the same cycle cancel out
                if (sram_rden && !freed)
                    cred <= cred - CRED_W'(1);
                else if (!sram_rden && freed)
                    cred <= cred + CRED_W'(1);
            end
        end
    end
endmodule

// File: rtl/vpu_src_operand_ctrl.sv
// Source operand sequencer: credit-limited SRAM row fetch per port, lockstep
// beat pop toward the lanes. Optional stall counter: VPU_SRC_CTRL_PERF_EN.
//
// state   | meaning
// IDLE    | waiting for start_i, inputs latched on start
// RUN     | fetching rows and popping beats
// DONE    | one-cycle done_o pulse, then back to IDLE
module vpu_src_operand_ctrl
    import vpu_src_operand_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [SRAM_R_PORT_CNT-1:0] src_mask_i,
    input  logic [SRAM_ADDR_W-1:0]     src_addr_i [SRAM_R_PORT_CNT],
    input  logic [ROW_CNT_W-1:0]       row_cnt_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [SRAM_R_PORT_CNT-1:0] sram_rden_o,
    output logic [SRAM_ADDR_W-1:0]     sram_raddr_o [SRAM_R_PORT_CNT],
    output logic [SRAM_R_PORT_CNT-1:0] q_wren_o,
    output logic [SRAM_R_PORT_CNT-1:0] q_rden_o,
    input  logic [SRAM_R_PORT_CNT-1:0] q_rdempty_i,
    input  logic                       issue_ready_i,
    output logic                       operand_valid_o,
    output logic [31:0]                perf_stall_cnt_o
);
    if (DIM_SIZE % BEAT_W != 0) begin : g_bad_beat_ratio
        $error("DIM_SIZE must be an integer multiple of BEAT_W");
    end

    src_ctrl_state_t            state;
    logic [SRAM_R_PORT_CNT-1:0] mask_q;
    logic [ROW_CNT_W-1:0]       pop_rows_left;
    logic [BEAT_CNT_W-1:0]      beat_cnt;
    logic                       start_hit;
    logic                       run;
    logic                       pop;
    logic                       beat_wrap;
    logic                       last_pop;

    assign start_hit = (state == ST_IDLE) & start_i;
    assign run       = (state == ST_RUN);
    // inactive ports never hold back the lockstep pop
    assign pop       = run & issue_ready_i & (&(~q_rdempty_i | ~mask_q));
    assign beat_wrap = pop & (beat_cnt == BEAT_CNT_W'(BEATS - 1));
    assign last_pop  = beat_wrap & (pop_rows_left == ROW_CNT_W'(1));

    assign q_rden_o        = {SRAM_R_PORT_CNT{pop}} & mask_q;
    assign operand_valid_o = pop;

    for (genvar p = 0; p < SRAM_R_PORT_CNT; p++) begin : g_port
        vpu_src_port_fetch u_fetch (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (start_hit),
            .active     (mask_q[p]),
            .run        (run),
            .row_free   (beat_wrap),
            .base_addr  (src_addr_i[p]),
            .row_cnt    (row_cnt_i),
            .sram_rden  (sram_rden_o[p]),
            .sram_raddr (sram_raddr_o[p]),
            .q_wren     (q_wren_o[p])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            mask_q        <= '0;
            pop_rows_left <= '0;
            beat_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        mask_q        <= src_mask_i;
                        pop_rows_left <= row_cnt_i;
                        beat_cnt      <= '0;
                        busy_o        <= 1'b1;
                        if (row_cnt_i == '0 || src_mask_i == '0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        beat_cnt <= beat_wrap ? '0 : beat_cnt + BEAT_CNT_W'(1);
                        if (beat_wrap)
                            pop_rows_left <= pop_rows_left - ROW_CNT_W'(1);
                        if (last_pop) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef VPU_SRC_CTRL_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (start_hit)
            stall_cnt <= '0;
        else if (run && issue_ready_i && !pop && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign perf_stall_cnt_o = stall_cnt;
`else
    assign perf_stall_cnt_o = '0;
`endif
endmodule
